ula_sequenciador: RTL and testbench
===================================

// Module: ula_sequenciador
// PURPOSE
//  Initiator/controller for the 8-bit signed ULA (AND/OR/ADD/SUB, FLAG_O). Accepts operation
//  commands on a valid/ready port, drives the ULA operands from an internal accumulator and
//  operand register, captures Saida/FLAG_O back into the accumulator, and returns each result
//  on a valid/ready response port. Keeps a sticky overflow flag across a chain of operations.
// PARAMETERS
//  NBITS  8  data width; must match the ULA's NBITS
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      block can accept a command (high only in IDLE)
//  cmd_load     in   1      1: acc <= cmd_operand (no ULA op); 0: acc <= acc OP cmd_operand
//  cmd_op       in   2      00 AND, 01 OR, 10 ADD, 11 SUB (ULA F encoding)
//  cmd_operand  in   NBITS  signed operand B (or load value)
//  clr_ovf      in   1      one-cycle pulse, clears sticky overflow
//  ula_a        out  NBITS  to ULA A = acc
//  ula_b        out  NBITS  to ULA B = operand register
//  ula_f        out  2      to ULA F = op register
//  ula_saida    in   NBITS  from ULA Saida
//  ula_flag_o   in   1      from ULA FLAG_O
//  res_valid    out  1      result present
//  res_ready    in   1      consumer takes result
//  res_data     out  NBITS  signed result (= new acc)
//  res_ovf      out  1      overflow of this operation
//  ovf_sticky   out  1      OR of res_ovf since last reset/clr_ovf
// BEHAVIOUR
//  - Reset: state IDLE; acc, opnd_reg, op_reg, res_data, res_ovf, ovf_sticky = 0; res_valid=0;
//    cmd_ready=1 on the first cycle after reset deasserts. ula_a/b/f = 0. Reset wins over all.
//  - ula_a/ula_b/ula_f driven straight from registers (acc/opnd_reg/op_reg); stable across EXEC.
//  - FSM IDLE -> EXEC -> RESP -> IDLE (ops); IDLE -> RESP -> IDLE (load).
//  - IDLE: cmd_ready=1. Handshake on cmd_valid&cmd_ready at edge N: latch cmd_op, cmd_operand.
//    load=1: acc<=cmd_operand, res_data<=cmd_operand, res_ovf<=0, -> RESP (res_valid at N+1).
//    load=0: opnd_reg<=cmd_operand, op_reg<=cmd_op, -> EXEC.
//  - EXEC (one cycle, cmd_ready=0): at its closing edge acc<=ula_saida, res_data<=ula_saida,
//    res_ovf<=ula_flag_o, ovf_sticky<=ovf_sticky|ula_flag_o; -> RESP (res_valid at N+2).
//  - RESP: res_valid=1, res_data/res_ovf held constant until res_valid&res_ready edge, then IDLE.
//    cmd_ready=0 in RESP; no command accepted in the handshake cycle (next accept earliest in IDLE).
//  - Throughput: one op per 3 cycles with res_ready tied high; load 2 cycles.
//  - Arithmetic: two's complement NBITS, wrap-around taken as the ULA produces it; flag from ULA only.
//  - clr_ovf: clears ovf_sticky in any state; if same edge as an EXEC capture with ula_flag_o=1,
//    sticky ends 1 (set wins). clr_ovf never alters res_ovf.
//  - cmd_op/cmd_operand ignored outside the accept handshake; cmd_valid while busy is held off.
//  - Reset mid EXEC/RESP: result discarded, no res_valid, all registers to reset values.
// TESTING
//  1. load 100, ADD 27 -> res 127 ovf0; ADD 1 -> res -128 (0x80) res_ovf1, ovf_sticky1.
//  2. load -128, SUB 1 -> res 127, res_ovf1; SUB 0 -> 127, res_ovf0, sticky stays 1.
//  3. load 0xF0, AND 0x3C -> 0x30; OR 0x05 -> 0x35; res_ovf0 throughout.
//  4. res_ready low 5 cycles in RESP -> res_valid/res_data stable, cmd_ready=0, cmd_valid ignored.
//  5. reset pulse during EXEC -> next cycle acc=0, res_valid=0, cmd_ready=1, ula_a/b/f=0.
//  6. clr_ovf coincident with EXEC capture of overflow -> ovf_sticky=1; clr_ovf alone later -> 0.

Source files
------------

// File: rtl/ula_sequenciador.sv
// Sequencer for the 8-bit signed ULA: accepts load/op commands, drives the ULA from
// internal accumulator/operand/op registers, captures its result and returns it on a response port.
module ula_sequenciador #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_op,
    input  logic [NBITS-1:0] cmd_operand,
    input  logic             clr_ovf,
    output logic [NBITS-1:0] ula_a,
    output logic [NBITS-1:0] ula_b,
    output logic [1:0]       ula_f,
    input  logic [NBITS-1:0] ula_saida,
    input  logic             ula_flag_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NBITS-1:0] res_data,
    output logic             res_ovf,
    output logic             ovf_sticky
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [NBITS-1:0] acc_q;
    logic [NBITS-1:0] opnd_q;
    logic [1:0]       op_q;
    logic [NBITS-1:0] res_data_q;
    logic             res_ovf_q;
    logic             sticky_q;
    logic             sticky_d;
    logic             cmd_ready_q;
    logic             res_valid_q;

    // Sticky overflow next state: a capture with overflow beats a coincident clear.
    always_comb begin
        sticky_d = sticky_q;
        if (state_q == S_EXEC) begin
            sticky_d = (sticky_q & ~clr_ovf) | ula_flag_o;
        end else if (clr_ovf) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Control FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= {NBITS{1'b0}};
            opnd_q      <= {NBITS{1'b0}};
            op_q        <= 2'b00;
            res_data_q  <= {NBITS{1'b0}};
            res_ovf_q   <= 1'b0;
            sticky_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_load) begin
                            acc_q       <= cmd_operand;
                            res_data_q  <= cmd_operand;
                            res_ovf_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            opnd_q  <= cmd_operand;
                            op_q    <= cmd_op;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    acc_q       <= ula_saida;
                    res_data_q  <= ula_saida;
                    res_ovf_q   <= ula_flag_o;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    // The accept edge only returns to IDLE; a new command waits a cycle.
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ula_a      = acc_q;
    assign ula_b      = opnd_q;
    assign ula_f      = op_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Scoreboard bench for ula_sequenciador: an ULA model closes the loop, an integer
// reference model predicts every response, and a monitor compares them.
module tb_ula_sequenciador;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [1:0] cmd_op;
    logic [7:0] cmd_operand;
    logic       clr_ovf;
    logic [7:0] ula_a, ula_b;
    logic [1:0] ula_f;
    logic [7:0] ula_saida;
    logic       ula_flag_o;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_ovf;
    logic       ovf_sticky;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
        logic       s;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    bit         rr_hold = 1'b0;
    logic [7:0] m_acc = 8'd0;
    bit         m_sticky = 1'b0;

    ula_sequenciador #(.NBITS(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand), .clr_ovf(clr_ovf),
        .ula_a(ula_a), .ula_b(ula_b), .ula_f(ula_f),
        .ula_saida(ula_saida), .ula_flag_o(ula_flag_o),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    // Combinational ULA: 9-bit sign-extended arithmetic, flag on signed overflow.
    always_comb begin
        logic [8:0] s9;
        s9         = 9'd0;
        ula_saida  = 8'd0;
        ula_flag_o = 1'b0;
        case (ula_f)
            2'b00: ula_saida = ula_a & ula_b;
            2'b01: ula_saida = ula_a | ula_b;
            2'b10: begin
                s9 = {ula_a[7], ula_a} + {ula_b[7], ula_b};
                ula_saida = s9[7:0];
                ula_flag_o = s9[8] ^ s9[7];
            end
            default: begin
                s9 = {ula_a[7], ula_a} - {ula_b[7], ula_b};
                ula_saida = s9[7:0];
                ula_flag_o = s9[8] ^ s9[7];
            end
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Consumer side: random backpressure unless a test holds it low.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = rr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every accepted response is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_response: got data %0d with nothing expected", res_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_data", res_data, e.d);
                    chk("res_ovf", res_ovf, e.o);
                    chk("ovf_sticky", ovf_sticky, e.s);
                end
            end
        end
    end

    // Issue one command when the block is ready and push its predicted response.
    task automatic issue(input bit load, input bit [1:0] op, input logic [7:0] opnd,
                         input bit clr_idle, input bit clr_exec, input bit rst_exec);
        int   n = 0;
        int   a, b, s;
        logic [7:0] r;
        bit   o;
        exp_t e;
        while (!cmd_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        cmd_valid   = 1'b1;
        cmd_load    = load;
        cmd_op      = op;
        cmd_operand = opnd;
        clr_ovf     = clr_idle;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_operand = 8'($urandom);
        cmd_load    = 1'($urandom);
        clr_ovf     = 1'b0;
        if (clr_idle) m_sticky = 1'b0;
        a = $signed(m_acc);
        b = $signed(opnd);
        o = 1'b0;
        if (load) begin
            r = opnd;
        end else begin
            case (op)
                2'b00: r = m_acc & opnd;
                2'b01: r = m_acc | opnd;
                2'b10: begin s = a + b; r = s[7:0]; o = (s > 127) || (s < -128); end
                default: begin s = a - b; r = s[7:0]; o = (s > 127) || (s < -128); end
            endcase
            if (clr_exec) m_sticky = 1'b0;
            m_sticky = m_sticky | o;
        end
        m_acc = r;
        if (rst_exec) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset    = 1'b0;
            m_acc    = 8'd0;
            m_sticky = 1'b0;
        end else begin
            e.d = r;
            e.o = o;
            e.s = m_sticky;
            sb_q.push_back(e);
            if (clr_exec) begin
                clr_ovf = 1'b1;
                @(posedge clk);
                #1;
                clr_ovf = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready && sb_q.size() == 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(cmd_ready && sb_q.size() == 0)) chk("idle_timeout", 0, 1);
    endtask

    // Directed scenarios followed by a randomized command stream.
    initial begin
        int n;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00; cmd_operand = 8'd0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_ula_a", ula_a, 0);
        chk("rst_ula_b", ula_b, 0);
        chk("rst_ula_f", ula_f, 0);
        chk("rst_sticky", ovf_sticky, 0);
        @(posedge clk);
        #1;

        // 127 + 1 wraps to -128 with overflow
        issue(1'b1, 2'b00, 8'd100, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b10, 8'd27, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b10, 8'd1, 1'b0, 1'b0, 1'b0);
        // -128 - 1 wraps to 127; following SUB 0 keeps sticky
        issue(1'b1, 2'b00, 8'h80, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 2'b11, 8'd1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b11, 8'd0, 1'b0, 1'b0, 1'b0);
        // logic ops
        issue(1'b1, 2'b00, 8'hF0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b00, 8'h3C, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b01, 8'h05, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("logic_acc", ula_a, 8'h35);

        // Held response under backpressure with a command knocking
        rr_hold = 1'b1;
        issue(1'b0, 2'b10, 8'd16, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b1;
        cmd_load = 1'b1;
        cmd_operand = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_data", res_data, m_acc);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rr_hold = 1'b0;
        wait_idle();

        // Reset during EXEC discards the operation
        issue(1'b1, 2'b00, 8'd55, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(1'b0, 2'b10, 8'd9, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rstx_ula_a", ula_a, 0);
        chk("rstx_ula_b", ula_b, 0);
        chk("rstx_ula_f", ula_f, 0);
        chk("rstx_res_valid", res_valid, 0);
        chk("rstx_cmd_ready", cmd_ready, 1);
        chk("rstx_res_data", res_data, 0);
        @(posedge clk);
        #1;
        sb_q.delete();

        // Clear coincident with an overflowing capture: set wins; lone clear later drops it
        issue(1'b1, 2'b00, 8'd120, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b10, 8'd120, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("sticky_set_wins", ovf_sticky, 1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        m_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", ovf_sticky, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            bit ld;
            ld = ($urandom_range(0, 4) == 0);
            issue(ld, 2'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0),
                  (!ld && $urandom_range(0, 9) == 0), 1'b0);
        end
        wait_idle();
        chk("final_acc", ula_a, m_acc);
        chk("final_sticky", ovf_sticky, m_sticky);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
